// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the front-end hazard controller: redirect FSM states
// and the ROB recovery-state encodings.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_FLUSH   = 2'd1,
    HZ_RECOVER = 2'd2
  } hz_state_t;

  typedef enum logic [1:0] {
    rob_idle     = 2'd0,
    rob_rollback = 2'd1,
    rob_walk     = 2'd2
  } rob_state_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Performance counters for the hazard controller: stall cycles, accepted
// redirects and recovery cycles. Each counter wraps at 2^CNT_W.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_en_i,
  input  logic             flush_en_i,
  input  logic             recov_en_i,
  output logic [CNT_W-1:0] stall_cyc_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] recov_cyc_o
);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] recov_q, recov_d;

  // Next counts: add one when the matching enable is set.
  always_comb begin
    stall_d = stall_q + CNT_W'(stall_en_i);
    flush_d = flush_q + CNT_W'(flush_en_i);
    recov_d = recov_q + CNT_W'(recov_en_i);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
      recov_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      recov_q <= recov_d;
    end
  end

  assign stall_cyc_o = stall_q;
  assign flush_cnt_o = flush_q;
  assign recov_cyc_o = recov_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end stall/flush controller. Produces per-stage stall and flush
// vectors for NUM_STAGES front-end registers (stage 0 = PC), with bubble
// collapsing backpressure, a multi-cycle flush hold after each redirect and
// a recovery FSM that follows the ROB state.
// Optional feature: define PIPE_HAZARD_PERF_EN to build the perf counters;
// otherwise the perf_* outputs are tied to zero.
//
// Handshake: can_dispatch is a ready for stage N-1; stage k counts as valid
// when stage_valid[k] is set, and a valid stage holds only while the stage
// downstream of it holds. An invalid stage never holds, so upstream refills it.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int FLUSH_HOLD = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  imem_miss,
  input  logic                  can_dispatch,
  input  logic                  flush_valid,
  input  logic [1:0]            rob_state,
  input  logic [NUM_STAGES-1:0] stage_valid,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic [1:0]            hz_state,
  output logic                  redirect_busy,
  output logic [CNT_W-1:0]      perf_stall_cyc,
  output logic [CNT_W-1:0]      perf_flush_cnt,
  output logic [CNT_W-1:0]      perf_recov_cyc
);

  localparam int HOLD_W = $clog2(FLUSH_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(FLUSH_HOLD - 1);

  hz_state_t         state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rob_busy;

  // The PC is always valid, so stage_valid[0] carries no information.
  logic unused_pc_valid;
  assign unused_pc_valid = stage_valid[0];

  assign rob_busy = (rob_state != rob_idle);

  // Run-mode stall chain: stage k holds when it and every stage downstream
  // of it are valid and dispatch is refusing. Written as an AND-reduction so
  // each bit depends only on inputs.
  logic [NUM_STAGES-1:1] stall_run;
  for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stall_chain
    assign stall_run[k] = (&stage_valid[NUM_STAGES-1:k]) & ~can_dispatch;
  end

  // Redirect FSM next-state and flush hold counter.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (flush_valid) begin
      state_d = HZ_FLUSH;
      hold_d  = HOLD_INIT;
    end else begin
      unique case (state_q)
        HZ_RUN: begin
          if (rob_busy) state_d = HZ_RECOVER;
        end
        HZ_FLUSH: begin
          if (hold_q == '0) state_d = rob_busy ? HZ_RECOVER : HZ_RUN;
          else              hold_d  = hold_q - HOLD_W'(1);
        end
        HZ_RECOVER: begin
          if (!rob_busy) state_d = HZ_RUN;
        end
        default: state_d = HZ_RUN;
      endcase
    end
  end

  // FSM state and hold counter registers; reset abandons any pending hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HZ_RUN;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Stall/flush outputs. Redirects win, then ROB activity, then run mode.
  // While recovering, the cycle the ROB reports idle already releases the
  // stalls (run-mode rules apply) even though the FSM leaves one cycle later.
  always_comb begin
    stall = '0;
    flush = '0;
    if (flush_valid || state_q == HZ_FLUSH) begin
      flush = '1;
    end else if (rob_busy) begin
      stall = '1;
    end else begin
      stall[NUM_STAGES-1:1] = stall_run;
      stall[0]              = imem_miss | stall_run[1];
      flush[1]              = imem_miss & ~stall_run[1];
    end
  end

  assign hz_state      = state_q;
  assign redirect_busy = (state_q != HZ_RUN);

`ifdef PIPE_HAZARD_PERF_EN
  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk         (clk),
    .reset       (reset),
    .stall_en_i  (stall[0]),
    .flush_en_i  (flush_valid),
    .recov_en_i  (state_q == HZ_RECOVER),
    .stall_cyc_o (perf_stall_cyc),
    .flush_cnt_o (perf_flush_cnt),
    .recov_cyc_o (perf_recov_cyc)
  );
`else
  assign perf_stall_cyc = '0;
  assign perf_flush_cnt = '0;
  assign perf_recov_cyc = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (NUM_STAGES=4, FLUSH_HOLD=3).
// Inputs change just after the falling edge; outputs are sampled 2 time
// units later, well away from the rising edge.
module tb_pipe_hazard_ctrl;

  localparam int N     = 4;
  localparam int HOLD  = 3;
  localparam int CW    = 32;

  localparam logic [1:0] RUN = 2'd0, FLS = 2'd1, REC = 2'd2;
  localparam logic [1:0] IDLE = 2'd0, WALK = 2'd2;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_miss, can_dispatch, flush_valid;
  logic [1:0]    rob_state;
  logic [N-1:0]  stage_valid;
  logic [N-1:0]  stall, flush;
  logic [1:0]    hz_state;
  logic          redirect_busy;
  logic [CW-1:0] perf_stall_cyc, perf_flush_cnt, perf_recov_cyc;

  int n_checks = 0;
  int n_pass   = 0;

  // Clock
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .NUM_STAGES(N),
    .FLUSH_HOLD(HOLD),
    .CNT_W     (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_miss      (imem_miss),
    .can_dispatch   (can_dispatch),
    .flush_valid    (flush_valid),
    .rob_state      (rob_state),
    .stage_valid    (stage_valid),
    .stall          (stall),
    .flush          (flush),
    .hz_state       (hz_state),
    .redirect_busy  (redirect_busy),
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_recov_cyc (perf_recov_cyc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Driver: apply one cycle of inputs after the falling edge, then settle.
  task automatic drive(input logic im, input logic cd, input logic fv,
                       input logic [1:0] rob, input logic [N-1:0] sv);
    @(negedge clk);
    imem_miss    = im;
    can_dispatch = cd;
    flush_valid  = fv;
    rob_state    = rob;
    stage_valid  = sv;
    #2;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b1, 1'b0, IDLE, 4'b1111);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [CW-1:0] exp_stall_cyc, exp_flush_cnt, exp_recov_cyc;

  initial begin
    reset = 1'b1; imem_miss = 1'b0; can_dispatch = 1'b1; flush_valid = 1'b0;
    rob_state = IDLE; stage_valid = 4'b1111;
    #12;
    check("rst_state", hz_state, RUN);
    check("rst_busy", redirect_busy, 1'b0);
    check("rst_perf_stall", perf_stall_cyc, 0);
    check("rst_perf_flush", perf_flush_cnt, 0);
    check("rst_perf_recov", perf_recov_cyc, 0);
    @(negedge clk);
    reset = 1'b0;

    // Run-mode backpressure and bubbles
    drive(1'b0, 1'b0, 1'b0, IDLE, 4'b1111);
    check("full_stall", stall, 4'b1111);
    check("full_stall_flush", flush, 4'b0000);
    drive(1'b0, 1'b1, 1'b0, IDLE, 4'b1111);
    check("dispatch_go", stall, 4'b0000);
    drive(1'b0, 1'b0, 1'b0, IDLE, 4'b1011);
    check("bubble2", stall, 4'b1000);
    drive(1'b0, 1'b0, 1'b0, IDLE, 4'b1101);
    check("bubble1", stall, 4'b1100);
    drive(1'b1, 1'b1, 1'b0, IDLE, 4'b1111);
    check("imiss_stall", stall, 4'b0001);
    check("imiss_flush", flush, 4'b0010);
    drive(1'b1, 1'b0, 1'b0, IDLE, 4'b1111);
    check("imiss_bp_stall", stall, 4'b1111);
    check("imiss_bp_flush", flush, 4'b0000);
    drive(1'b1, 1'b0, 1'b0, IDLE, 4'b0111);
    check("imiss_lastbub_stall", stall, 4'b0001);
    check("imiss_lastbub_flush", flush, 4'b0010);

    // Redirect with ROB walk: 1 pulse cycle + 3 hold cycles of flush
    drive(1'b0, 1'b1, 1'b1, WALK, 4'b1111);
    check("pulse_flush", flush, 4'b1111);
    check("pulse_stall", stall, 4'b0000);
    check("pulse_state", hz_state, RUN);
    for (int i = 0; i < HOLD; i++) begin
      drive(1'b0, 1'b1, 1'b0, WALK, 4'b1111);
      check($sformatf("hold%0d_flush", i), flush, 4'b1111);
      check($sformatf("hold%0d_state", i), hz_state, FLS);
      check($sformatf("hold%0d_busy", i), redirect_busy, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, WALK, 4'b1111);
      check($sformatf("recov%0d_stall", i), stall, 4'b1111);
      check($sformatf("recov%0d_flush", i), flush, 4'b0000);
      check($sformatf("recov%0d_state", i), hz_state, REC);
      check($sformatf("recov%0d_busy", i), redirect_busy, 1'b1);
    end
    idle_cycle();
    check("recov_exit_stall", stall, 4'b0000);
    check("recov_exit_state", hz_state, REC);
    idle_cycle();
    check("back_run_state", hz_state, RUN);
    check("back_run_busy", redirect_busy, 1'b0);

    // Re-arm: a second pulse inside the hold restarts the full hold
    drive(1'b0, 1'b1, 1'b1, IDLE, 4'b1111);
    drive(1'b0, 1'b1, 1'b1, IDLE, 4'b1111);
    check("rearm_pulse_state", hz_state, FLS);
    for (int i = 0; i < HOLD; i++) begin
      idle_cycle();
      check($sformatf("rearm%0d_state", i), hz_state, FLS);
    end
    idle_cycle();
    check("rearm_done_state", hz_state, RUN);

    // Flush during recovery, then reset mid-hold
    drive(1'b0, 1'b1, 1'b0, WALK, 4'b1111);
    check("rob_leave_idle_stall", stall, 4'b1111);
    check("rob_leave_idle_state", hz_state, RUN);
    drive(1'b0, 1'b1, 1'b1, WALK, 4'b1111);
    check("recov_flush_state", hz_state, REC);
    check("recov_flush_flush", flush, 4'b1111);
    check("recov_flush_stall", stall, 4'b0000);
    drive(1'b0, 1'b1, 1'b0, IDLE, 4'b1111);
    check("recov_flush_next", hz_state, FLS);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("midhold_rst_state", hz_state, RUN);
    check("midhold_rst_flush", flush, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    idle_cycle();
    check("after_rst_state", hz_state, RUN);

    // Perf scenario: 2 miss-stall cycles, 2 flushes, recovery adds 3 stall
    // cycles (1 in RUN, 2 in RECOVER) and 3 recover cycles.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, IDLE, 4'b1111);
    drive(1'b1, 1'b1, 1'b0, IDLE, 4'b1111);
    for (int f = 0; f < 2; f++) begin
      drive(1'b0, 1'b1, 1'b1, IDLE, 4'b1111);
      for (int i = 0; i < HOLD; i++) idle_cycle();
    end
    drive(1'b0, 1'b1, 1'b0, WALK, 4'b1111);
    drive(1'b0, 1'b1, 1'b0, WALK, 4'b1111);
    drive(1'b0, 1'b1, 1'b0, WALK, 4'b1111);
    idle_cycle();
    idle_cycle();
    check("perf_state_run", hz_state, RUN);
`ifdef PIPE_HAZARD_PERF_EN
    exp_stall_cyc = 5; exp_flush_cnt = 2; exp_recov_cyc = 3;
`else
    exp_stall_cyc = 0; exp_flush_cnt = 0; exp_recov_cyc = 0;
`endif
    check("perf_stall_cyc", perf_stall_cyc, exp_stall_cyc);
    check("perf_flush_cnt", perf_flush_cnt, exp_flush_cnt);
    check("perf_recov_cyc", perf_recov_cyc, exp_recov_cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
